// File: rtl/io_pad_bank_ccff.sv
// I/O pad bank on one ccff chain segment: per-channel dir/inv_out/inv_in config with staggered isolation release.
// Optional parallel readback of the active image into the chain when IO_BANK_READBACK_EN is defined.
module io_pad_bank_ccff #(
  parameter int NUM_IO      = 8,
  parameter int RELEASE_GAP = 4
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              IO_ISOL_N,
  input  logic              config_enable,
  input  logic              config_readback,
  input  logic              cfg_commit,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic [NUM_IO-1:0] iopad_outpad,
  output logic [NUM_IO-1:0] iopad_inpad,
  input  logic [NUM_IO-1:0] gfpga_pad_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_SOC_DIR,
  output logic              release_done
);
  localparam int L = 3 * NUM_IO;
  localparam logic [7:0] GAP_LAST = 8'(RELEASE_GAP - 1);

  typedef enum logic [1:0] {ST_ISOLATED, ST_RELEASING, ST_ACTIVE} state_e;

  logic [L-1:0]      chain_q, chain_d;
  logic [L-1:0]      active_q;
  logic              cfg_valid_q;
  logic              sync1_q, isol_s_q;
  state_e            state_q, state_d;
  logic [NUM_IO-1:0] released_q, released_d;
  logic [7:0]        gap_q, gap_d;
  logic              capture;

`ifdef IO_BANK_READBACK_EN
  logic rb_q;
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) rb_q <= 1'b0;
    else           rb_q <= config_readback;
  end
  assign capture = config_readback & ~rb_q;
`else
  logic unused_readback;
  assign unused_readback = config_readback;
  assign capture = 1'b0;
`endif

  // Parallel capture takes priority over a shift in the same cycle.
  always_comb begin
    chain_d = chain_q;
    if (capture)            chain_d = active_q;
    else if (config_enable) chain_d = {chain_q[L-2:0], ccff_head};
  end

  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      chain_q     <= '0;
      active_q    <= '0;
      cfg_valid_q <= 1'b0;
      sync1_q     <= 1'b0;
      isol_s_q    <= 1'b0;
      state_q     <= ST_ISOLATED;
      released_q  <= '0;
      gap_q       <= '0;
    end else begin
      chain_q    <= chain_d;
      sync1_q    <= IO_ISOL_N;
      isol_s_q   <= sync1_q;
      state_q    <= state_d;
      released_q <= released_d;
      gap_q      <= gap_d;
      if (cfg_commit) begin
        active_q    <= chain_q;
        cfg_valid_q <= 1'b1;
      end
    end
  end

  // Release sequencer: one more channel every RELEASE_GAP cycles.
  always_comb begin
    state_d    = state_q;
    released_d = released_q;
    gap_d      = gap_q;
    if (!isol_s_q) begin
      state_d    = ST_ISOLATED;
      released_d = '0;
      gap_d      = '0;
    end else begin
      case (state_q)
        ST_ISOLATED: begin
          if (cfg_valid_q) begin
            state_d    = ST_RELEASING;
            released_d = NUM_IO'(1);
            gap_d      = '0;
          end
        end
        ST_RELEASING: begin
          if (released_q[NUM_IO-1]) begin
            state_d = ST_ACTIVE;
          end else if (gap_q == GAP_LAST) begin
            released_d = (released_q << 1) | NUM_IO'(1);
            gap_d      = '0;
          end else begin
            gap_d = gap_q + 8'd1;
          end
        end
        ST_ACTIVE: ;
        default: state_d = ST_ISOLATED;
      endcase
    end
  end

  assign release_done = (state_q == ST_ACTIVE);
  assign ccff_tail    = chain_q[L-1];

  // Raw IO_ISOL_N gates the pads so isolation does not wait on the synchroniser.
  for (genvar i = 0; i < NUM_IO; i++) begin : g_ch
    logic en;
    assign en                   = released_q[i] & IO_ISOL_N;
    assign gfpga_pad_SOC_DIR[i] = en & active_q[3*i];
    assign gfpga_pad_SOC_OUT[i] = en & (iopad_outpad[i] ^ active_q[3*i+1]);
    assign iopad_inpad[i]       = en & (gfpga_pad_SOC_IN[i] ^ active_q[3*i+2]);
  end
endmodule

// File: tb/tb_io_pad_bank_ccff.sv
// Scoreboard bench for io_pad_bank_ccff with NUM_IO=4, RELEASE_GAP=4.
module tb_io_pad_bank_ccff;
  logic       prog_clk, pReset_n, IO_ISOL_N, config_enable, config_readback, cfg_commit, ccff_head;
  logic       ccff_tail, release_done;
  logic [3:0] iopad_outpad, iopad_inpad, soc_in, soc_out, soc_dir;

  int total = 0;
  int bad   = 0;

  typedef struct { string tag; logic [31:0] exp; } sb_t;
  sb_t sb_q[$];

  io_pad_bank_ccff #(.NUM_IO(4), .RELEASE_GAP(4)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .IO_ISOL_N(IO_ISOL_N),
    .config_enable(config_enable), .config_readback(config_readback),
    .cfg_commit(cfg_commit), .ccff_head(ccff_head), .ccff_tail(ccff_tail),
    .iopad_outpad(iopad_outpad), .iopad_inpad(iopad_inpad),
    .gfpga_pad_SOC_IN(soc_in), .gfpga_pad_SOC_OUT(soc_out),
    .gfpga_pad_SOC_DIR(soc_dir), .release_done(release_done)
  );

  initial begin
    prog_clk = 1'b0;
    forever #5 prog_clk = ~prog_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time exhausted");
    $fatal(1);
  end

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic sb_push(input string tag, input logic [31:0] e);
    sb_t s;
    s.tag = tag;
    s.exp = e;
    sb_q.push_back(s);
  endtask

  task automatic sb_pop(input logic [31:0] got);
    sb_t s;
    if (sb_q.size() == 0) begin
      chk_val("sb_underflow", 32'd1, 32'd0);
    end else begin
      s = sb_q.pop_front();
      chk_val(s.tag, got, s.exp);
    end
  endtask

  task automatic shift_word(input logic [11:0] v);
    for (int k = 11; k >= 0; k--) begin
      @(negedge prog_clk);
      ccff_head     = v[k];
      config_enable = 1'b1;
    end
    @(negedge prog_clk);
    config_enable = 1'b0;
    ccff_head     = 1'b0;
  endtask

  task automatic commit();
    @(negedge prog_clk);
    cfg_commit = 1'b1;
    @(negedge prog_clk);
    cfg_commit = 1'b0;
  endtask

  // Called at the negedge where IO_ISOL_N has just risen; cycle c = c-th rising edge after it.
  task automatic check_release(input int ncyc, input logic [3:0] outpad, input logic [3:0] sin);
    for (int c = 1; c <= ncyc; c++) begin
      logic [3:0] m;
      m = 4'b0000;
      for (int n = 0; n < 4; n++) if (c >= 3 + 4 * n) m[n] = 1'b1;
      sb_push($sformatf("dir_c%0d", c), {28'd0, m});
      sb_push($sformatf("out_c%0d", c), {28'd0, outpad & m});
      sb_push($sformatf("inp_c%0d", c), {28'd0, sin & m});
      sb_push($sformatf("done_c%0d", c), {31'd0, (c >= 16)});
      @(posedge prog_clk);
      #1;
      sb_pop({28'd0, soc_dir});
      sb_pop({28'd0, soc_out});
      sb_pop({28'd0, iopad_inpad});
      sb_pop({31'd0, release_done});
    end
  endtask

  initial begin
    logic [23:0] seq;
    logic [11:0] rb;
    logic [11:0] rb_exp;
    pReset_n = 1'b0; IO_ISOL_N = 1'b0; config_enable = 1'b0; config_readback = 1'b0;
    cfg_commit = 1'b0; ccff_head = 1'b0; iopad_outpad = 4'b0; soc_in = 4'b0;
    #1;
    chk_val("rst_tail", {31'd0, ccff_tail}, 32'd0);
    chk_val("rst_done", {31'd0, release_done}, 32'd0);
    chk_val("rst_dir", {28'd0, soc_dir}, 32'd0);
    chk_val("rst_out", {28'd0, soc_out}, 32'd0);
    chk_val("rst_inp", {28'd0, iopad_inpad}, 32'd0);
    repeat (2) @(negedge prog_clk);
    pReset_n = 1'b1;

    // Chain pass-through: 0x5A3 then zeros, tail lags by 12 shifts.
    seq = {12'h5A3, 12'h000};
    for (int j = 0; j < 24; j++) begin
      @(negedge prog_clk);
      ccff_head     = seq[23-j];
      config_enable = 1'b1;
      sb_push($sformatf("tail_s%0d", j), (j >= 11) ? {31'd0, seq[23-(j-11)]} : 32'd0);
      @(posedge prog_clk);
      #1;
      sb_pop({31'd0, ccff_tail});
    end
    @(negedge prog_clk);
    config_enable = 1'b0;
    ccff_head     = 1'b0;

    // All channels dir=1, then staggered release.
    shift_word(12'h249);
    commit();
    iopad_outpad = 4'b1010;
    soc_in       = 4'b0110;
    IO_ISOL_N    = 1'b1;
    check_release(18, 4'b1010, 4'b0110);

    // Inversion on ch2, committed while active.
    shift_word(12'h3C9);
    commit();
    iopad_outpad = 4'b0100;
    soc_in       = 4'b0101;
    #1;
    chk_val("inv_dir", {28'd0, soc_dir}, 32'hF);
    chk_val("inv_out", {28'd0, soc_out}, 32'h0);
    chk_val("inv_inp", {28'd0, iopad_inpad}, 32'h1);
    iopad_outpad = 4'b1111;
    #1;
    chk_val("inv_out_all", {28'd0, soc_out}, 32'hB);

    // Mid-release isolation and restart.
    @(negedge prog_clk);
    IO_ISOL_N = 1'b0;
    #1;
    chk_val("isol_dir_now", {28'd0, soc_dir}, 32'h0);
    shift_word(12'h249);
    commit();
    iopad_outpad = 4'b1010;
    soc_in       = 4'b0110;
    IO_ISOL_N    = 1'b1;
    check_release(8, 4'b1010, 4'b0110);
    @(negedge prog_clk);
    IO_ISOL_N = 1'b0;
    #1;
    chk_val("mid_isol_dir", {28'd0, soc_dir}, 32'h0);
    chk_val("mid_isol_out", {28'd0, soc_out}, 32'h0);
    repeat (5) @(negedge prog_clk);
    IO_ISOL_N = 1'b1;
    check_release(5, 4'b1010, 4'b0110);

    // Async reset mid-sequence, then no release without a fresh commit.
    @(negedge prog_clk);
    pReset_n = 1'b0;
    #1;
    chk_val("rst_mid_dir", {28'd0, soc_dir}, 32'h0);
    chk_val("rst_mid_out", {28'd0, soc_out}, 32'h0);
    chk_val("rst_mid_inp", {28'd0, iopad_inpad}, 32'h0);
    @(negedge prog_clk);
    pReset_n = 1'b1;
    repeat (20) @(posedge prog_clk);
    #1;
    chk_val("nocommit_done", {31'd0, release_done}, 32'd0);
    chk_val("nocommit_dir", {28'd0, soc_dir}, 32'h0);
    chk_val("nocommit_out", {28'd0, soc_out}, 32'h0);

    // Readback of the active image versus plain chain content.
    shift_word(12'hA5C);
    commit();
    shift_word(12'h3F0);
    @(negedge prog_clk);
    config_readback = 1'b1;
    @(negedge prog_clk);
    config_readback = 1'b0;
`ifdef IO_BANK_READBACK_EN
    rb_exp = 12'hA5C;
`else
    rb_exp = 12'h3F0;
`endif
    rb = 12'h000;
    for (int k = 11; k >= 0; k--) begin
      @(negedge prog_clk);
      rb[k]         = ccff_tail;
      ccff_head     = 1'b0;
      config_enable = 1'b1;
    end
    @(negedge prog_clk);
    config_enable = 1'b0;
    chk_val("readback", {20'd0, rb}, {20'd0, rb_exp});

    chk_val("sb_left", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
